// File: rtl/rf_write_arbiter.sv
// Register-file write-port arbiter: WB has priority, LU results queue in a FIFO with an age-forced steal.
// Optional pending-register lookup enabled by defining RF_ARB_PENDCHK_EN.
module rf_write_arbiter #(
    parameter int DEPTH    = 4,
    parameter int MAX_WAIT = 8
) (
    input  logic                     clk_i,
    input  logic                     rst_n,
    input  logic                     wb_we_i,
    input  logic [4:0]               wb_addr_i,
    input  logic [31:0]              wb_data_i,
    input  logic                     lu_valid_i,
    output logic                     lu_ready_o,
    input  logic [4:0]               lu_addr_i,
    input  logic [31:0]              lu_data_i,
    output logic                     rf_we_o,
    output logic [4:0]               rf_addr_o,
    output logic [31:0]              rf_data_o,
    output logic                     stall_o,
`ifdef RF_ARB_PENDCHK_EN
    input  logic [4:0]               chk_addr_i,
    output logic                     chk_hit_o,
`endif
    output logic [$clog2(DEPTH):0]   pend_cnt_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int AGE_W = $clog2(MAX_WAIT) + 1;
    localparam logic [AGE_W-1:0] AGE_LIMIT = AGE_W'(MAX_WAIT - 1);

    typedef enum logic {
        ST_NORMAL = 1'b0,
        ST_STEAL  = 1'b1
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [4:0]         r_addr_mem [DEPTH];
    logic [31:0]        r_data_mem [DEPTH];
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [CNT_W-1:0]   r_count;
    logic [AGE_W-1:0]   r_age;
    logic [AGE_W-1:0]   w_age_nxt;
    logic               r_rf_we;
    logic [4:0]         r_rf_addr;
    logic [31:0]        r_rf_data;
    logic               r_stall;
    logic               w_rf_we_nxt;
    logic [4:0]         w_rf_addr_nxt;
    logic [31:0]        w_rf_data_nxt;
    logic               w_stall_nxt;
    logic               w_pop;
    logic               w_push;
    logic               w_wb_eff;
    logic               w_fifo_ne;
    logic               w_ready;

    assign w_ready    = (r_count != CNT_W'(DEPTH));
    assign w_fifo_ne  = (r_count != {CNT_W{1'b0}});
    assign w_wb_eff   = wb_we_i && (wb_addr_i != 5'd0);
    // Writes to $0 are acknowledged but never occupy a slot.
    assign w_push     = lu_valid_i && w_ready && (lu_addr_i != 5'd0);

    assign lu_ready_o = w_ready;
    assign rf_we_o    = r_rf_we;
    assign rf_addr_o  = r_rf_addr;
    assign rf_data_o  = r_rf_data;
    assign stall_o    = r_stall;
    assign pend_cnt_o = r_count;

    always_comb begin
        w_state_nxt   = r_state;
        w_age_nxt     = {AGE_W{1'b0}};
        w_rf_we_nxt   = 1'b0;
        w_rf_addr_nxt = r_rf_addr;
        w_rf_data_nxt = r_rf_data;
        w_stall_nxt   = 1'b0;
        w_pop         = 1'b0;
        case (r_state)
            ST_NORMAL: begin
                if (w_wb_eff) begin
                    w_rf_we_nxt   = 1'b1;
                    w_rf_addr_nxt = wb_addr_i;
                    w_rf_data_nxt = wb_data_i;
                    if (w_fifo_ne) begin
                        w_age_nxt = r_age + AGE_W'(1);
                        if (r_age == AGE_LIMIT) begin
                            w_stall_nxt = 1'b1;
                            w_state_nxt = ST_STEAL;
                        end else begin
                            w_state_nxt = ST_NORMAL;
                        end
                    end else begin
                        w_age_nxt = {AGE_W{1'b0}};
                    end
                end else if (w_fifo_ne) begin
                    w_pop         = 1'b1;
                    w_rf_we_nxt   = 1'b1;
                    w_rf_addr_nxt = r_addr_mem[r_rd_ptr];
                    w_rf_data_nxt = r_data_mem[r_rd_ptr];
                end else begin
                    w_rf_we_nxt = 1'b0;
                end
            end
            ST_STEAL: begin
                // The pipeline is held this cycle, so WB is ignored and re-presented later.
                w_state_nxt = ST_NORMAL;
                if (w_fifo_ne) begin
                    w_pop         = 1'b1;
                    w_rf_we_nxt   = 1'b1;
                    w_rf_addr_nxt = r_addr_mem[r_rd_ptr];
                    w_rf_data_nxt = r_data_mem[r_rd_ptr];
                end else begin
                    w_rf_we_nxt = 1'b0;
                end
            end
            default: begin
                w_state_nxt = ST_NORMAL;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n) begin
            r_state   <= ST_NORMAL;
            r_age     <= {AGE_W{1'b0}};
            r_rf_we   <= 1'b0;
            r_rf_addr <= 5'd0;
            r_rf_data <= 32'd0;
            r_stall   <= 1'b0;
            r_wr_ptr  <= {PTR_W{1'b0}};
            r_rd_ptr  <= {PTR_W{1'b0}};
            r_count   <= {CNT_W{1'b0}};
        end else begin
            r_state   <= w_state_nxt;
            r_age     <= w_age_nxt;
            r_rf_we   <= w_rf_we_nxt;
            r_rf_addr <= w_rf_addr_nxt;
            r_rf_data <= w_rf_data_nxt;
            r_stall   <= w_stall_nxt;
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_addr_mem[r_wr_ptr] <= lu_addr_i;
            r_data_mem[r_wr_ptr] <= lu_data_i;
        end
    end

`ifdef RF_ARB_PENDCHK_EN
    logic [DEPTH-1:0] w_slot_hit;

    // A slot is live when its distance from the read pointer is below the occupancy.
    for (genvar g = 0; g < DEPTH; g++) begin : g_slot
        logic [PTR_W-1:0] w_off;
        assign w_off         = PTR_W'(g) - r_rd_ptr;
        assign w_slot_hit[g] = ({1'b0, w_off} < r_count) && (r_addr_mem[g] == chk_addr_i);
    end

    assign chk_hit_o = (chk_addr_i != 5'd0) &&
                       ((|w_slot_hit) || (r_rf_we && (r_rf_addr == chk_addr_i)));
`endif

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Randomised bench for rf_write_arbiter against a queue-based behavioural model.
module tb_rf_write_arbiter;

    localparam int DEPTH    = 4;
    localparam int MAX_WAIT = 8;

    logic        clk_i = 1'b0;
    logic        rst_n;
    logic        wb_we_i;
    logic [4:0]  wb_addr_i;
    logic [31:0] wb_data_i;
    logic        lu_valid_i;
    logic        lu_ready_o;
    logic [4:0]  lu_addr_i;
    logic [31:0] lu_data_i;
    logic        rf_we_o;
    logic [4:0]  rf_addr_o;
    logic [31:0] rf_data_o;
    logic        stall_o;
    logic [2:0]  pend_cnt_o;
    logic [4:0]  chk_addr_i;
`ifdef RF_ARB_PENDCHK_EN
    logic        chk_hit_o;
`endif

    rf_write_arbiter #(.DEPTH(DEPTH), .MAX_WAIT(MAX_WAIT)) dut (
        .clk_i      (clk_i),
        .rst_n      (rst_n),
        .wb_we_i    (wb_we_i),
        .wb_addr_i  (wb_addr_i),
        .wb_data_i  (wb_data_i),
        .lu_valid_i (lu_valid_i),
        .lu_ready_o (lu_ready_o),
        .lu_addr_i  (lu_addr_i),
        .lu_data_i  (lu_data_i),
        .rf_we_o    (rf_we_o),
        .rf_addr_o  (rf_addr_o),
        .rf_data_o  (rf_data_o),
        .stall_o    (stall_o),
`ifdef RF_ARB_PENDCHK_EN
        .chk_addr_i (chk_addr_i),
        .chk_hit_o  (chk_hit_o),
`endif
        .pend_cnt_o (pend_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    int n_checks = 0;
    int n_errors = 0;

    // Behavioural model: pending LU results in arrival order, plus cycles the oldest has waited.
    logic [36:0] m_q[$];
    int          m_wait;
    bit          m_steal;
    bit          m_known = 1'b0;
    logic        m_we;
    logic [4:0]  m_addr;
    logic [31:0] m_data;
    logic        m_stall;
    bit          lu_acc;
    int          stall_seen;

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic pop_model();
        logic [36:0] head;
        head   = m_q.pop_front();
        m_we   = 1'b1;
        m_addr = head[36:32];
        m_data = head[31:0];
    endtask

    // One clock: check outputs, apply inputs, advance the model, wait for the next negedge.
    task automatic step(input logic rst, input logic we, input logic [4:0] wa, input logic [31:0] wd,
                        input logic lv, input logic [4:0] la, input logic [31:0] ld, input logic [4:0] ca);
        bit ready;
        bit had_entry;
        if (m_known) begin
            chk_eq("rf_we", {31'd0, rf_we_o}, {31'd0, m_we});
            chk_eq("rf_addr", {27'd0, rf_addr_o}, {27'd0, m_addr});
            chk_eq("rf_data", rf_data_o, m_data);
            chk_eq("stall", {31'd0, stall_o}, {31'd0, m_stall});
            chk_eq("pend_cnt", {29'd0, pend_cnt_o}, m_q.size());
            chk_eq("lu_ready", {31'd0, lu_ready_o}, {31'd0, (m_q.size() < DEPTH)});
        end
        if (stall_o === 1'b1) stall_seen++;
        rst_n = rst; wb_we_i = we; wb_addr_i = wa; wb_data_i = wd;
        lu_valid_i = lv; lu_addr_i = la; lu_data_i = ld; chk_addr_i = ca;
        #1;
`ifdef RF_ARB_PENDCHK_EN
        if (m_known) begin
            bit hit;
            hit = m_we && (m_addr == ca);
            foreach (m_q[i]) if (m_q[i][36:32] == ca) hit = 1'b1;
            if (ca == 5'd0) hit = 1'b0;
            chk_eq("chk_hit", {31'd0, chk_hit_o}, {31'd0, hit});
        end
`endif
        ready  = (m_q.size() < DEPTH);
        lu_acc = rst && lv && ready;
        if (!rst) begin
            m_q.delete();
            m_wait = 0; m_steal = 1'b0; m_known = 1'b1;
            m_we = 1'b0; m_addr = 5'd0; m_data = 32'd0; m_stall = 1'b0;
        end else if (m_known) begin
            had_entry = (m_q.size() > 0);
            m_stall   = 1'b0;
            if (m_steal) begin
                m_steal = 1'b0;
                m_wait  = 0;
                if (had_entry) pop_model(); else m_we = 1'b0;
            end else if (we && wa != 5'd0) begin
                m_we = 1'b1; m_addr = wa; m_data = wd;
                if (had_entry) begin
                    if (m_wait == MAX_WAIT - 1) begin
                        m_stall = 1'b1;
                        m_steal = 1'b1;
                    end
                    m_wait++;
                end else begin
                    m_wait = 0;
                end
            end else if (had_entry) begin
                pop_model();
                m_wait = 0;
            end else begin
                m_we = 1'b0;
                m_wait = 0;
            end
            if (lu_acc && la != 5'd0) m_q.push_back({la, ld});
        end
        @(negedge clk_i);
    endtask

    initial begin
        int   tries;
        int   nacked;
        logic rl_v;
        logic [4:0] rl_a;
        logic [31:0] rl_d;
        bit   hold;

        rst_n = 1'b0; wb_we_i = 1'b0; wb_addr_i = 5'd0; wb_data_i = 32'd0;
        lu_valid_i = 1'b0; lu_addr_i = 5'd0; lu_data_i = 32'd0; chk_addr_i = 5'd0;
        stall_seen = 0;
        @(negedge clk_i);

        // Reset held two cycles with traffic present
        step(1'b0, 1'b1, 5'd5, 32'h1111_1111, 1'b1, 5'd6, 32'h2222_2222, 5'd6);
        step(1'b0, 1'b1, 5'd5, 32'h1111_1111, 1'b1, 5'd6, 32'h2222_2222, 5'd6);
        chk_eq("reset_we", {31'd0, rf_we_o}, 32'd0);
        chk_eq("reset_cnt", {29'd0, pend_cnt_o}, 32'd0);
        chk_eq("reset_ready", {31'd0, lu_ready_o}, 32'd1);

        // WB only, then a WB write to $0
        step(1'b1, 1'b1, 5'd5, 32'hDEAD_BEEF, 1'b0, 5'd0, 32'd0, 5'd5);
        chk_eq("wb_addr5", {27'd0, rf_addr_o}, 32'd5);
        chk_eq("wb_data", rf_data_o, 32'hDEAD_BEEF);
        step(1'b1, 1'b1, 5'd0, 32'hCAFE_F00D, 1'b0, 5'd0, 32'd0, 5'd0);
        chk_eq("wb_zero_we", {31'd0, rf_we_o}, 32'd0);
        step(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd0);

        // LU with idle pipeline
        step(1'b1, 1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'h1234_5678, 5'd7);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd7);

        // Starvation: one LU entry behind continuous WB traffic
        stall_seen = 0;
        step(1'b1, 1'b1, 5'd3, 32'hAAAA_0003, 1'b1, 5'd9, 32'h0000_0099, 5'd9);
        for (int i = 0; i < 14; i++)
            step(1'b1, 1'b1, 5'd3, 32'hAAAA_0003 + i, 1'b0, 5'd0, 32'd0, 5'd9);
        for (int i = 0; i < 2; i++) step(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd9);
        chk_eq("starve_stall_cnt", stall_seen, 32'd1);

        // Fill the FIFO behind busy WB, then a fifth push must wait
        nacked = 0;
        for (int k = 1; k <= 5; k++) begin
            tries = 0;
            do begin
                step(1'b1, 1'b1, 5'd4, 32'h4444_0000 + k, 1'b1, 5'(10 + k), 32'h5000_0000 + k, 5'(10 + k));
                if (!lu_acc) nacked++;
                tries++;
            end while (!lu_acc && tries < 40);
            if (!lu_acc) chk_eq("full_push_timeout", {31'd0, lu_acc}, 32'd1);
        end
        chk_eq("full_nacked", {31'd0, (nacked > 0)}, 32'd1);
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd12);

        // Random traffic with an LU source that honours ready
        hold = 1'b0; rl_v = 1'b0; rl_a = 5'd0; rl_d = 32'd0;
        for (int n = 0; n < 1500; n++) begin
            logic rst;
            logic we;
            rst = ($urandom_range(0, 149) != 0);
            if (!hold) begin
                rl_v = ($urandom_range(0, 99) < 40);
                rl_a = 5'($urandom_range(0, 12));
                rl_d = $urandom;
            end
            we = ($urandom_range(0, 99) < ((n / 250) % 2 == 0 ? 60 : 95));
            step(rst, we, 5'($urandom_range(0, 12)), $urandom, rl_v, rl_a, rl_d,
                 5'($urandom_range(0, 12)));
            hold = rst && rl_v && !lu_acc;
        end
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/rf_write_arbiter.md
Name: rf_write_arbiter

Overview:
- Shares the register file's single write port between two writers: the pipeline writeback stage (WB) and a long-latency unit (LU, e.g. multiply/divide).
- WB normally has priority. LU results wait in a small FIFO.
- An age counter forces a one-cycle pipeline stall when the FIFO head has waited too long, guaranteeing LU forward progress.
- Outputs are registered and drive the register file's write enable, address and data directly.

Parameters:
- DEPTH, 4, LU pending-FIFO entries (power of 2, ≥2)
- MAX_WAIT, 8, cycles the FIFO head may wait before a forced steal (≥1)

Ports:
- clk_i  in  1  clock; all state updates on posedge
- rst_n  in  1  reset, synchronous, active-low
- wb_we_i  in  1  WB write request
- wb_addr_i  in  5  WB destination register
- wb_data_i  in  32  WB write data
- lu_valid_i  in  1  LU result valid
- lu_ready_o  out  1  FIFO can accept (combinational, = count<DEPTH)
- lu_addr_i  in  5  LU destination register
- lu_data_i  in  32  LU result data
- rf_we_o  out  1  register-file write enable (registered)
- rf_addr_o  out  5  register-file write address (registered)
- rf_data_o  out  32  register-file write data (registered)
- stall_o  out  1  pipeline hold request (registered)
- pend_cnt_o  out  $clog2(DEPTH)+1  FIFO occupancy

Behaviour:
- Reset (rst_n=0 at posedge): FIFO empty, pend_cnt_o=0, age=0, state=NORMAL, rf_we_o=0, rf_addr_o=0, rf_data_o=0, stall_o=0. lu_ready_o=1 after reset. Reset mid-operation discards all pending entries.
- Push: on lu_valid_i && lu_ready_o. If lu_addr_i==0, the result is accepted but discarded, with no push.
- WB request is effective only when wb_we_i && wb_addr_i!=0. Writes to $0 are dropped and consume no slot.
- Arbitration uses pre-edge state. An entry pushed this cycle cannot pop this cycle, so its minimum FIFO residency is 1 cycle.
- State NORMAL:
  - Effective WB request → rf_* <= WB, we=1.
  - Else FIFO non-empty → pop head to rf_*, we=1.
  - Else rf_we_o <= 0. rf_addr_o/rf_data_o hold their last values.
- Age counter: in NORMAL, increments each cycle the FIFO is non-empty and no pop occurs; clears on any pop or when empty.
- When age==MAX_WAIT-1 and WB wins again: stall_o <= 1 and state <= STEAL.
- State STEAL (stall_o=1 for exactly this cycle):
  - Pipeline holds WB, so wb_* is ignored this cycle and re-presented next cycle.
  - Pop FIFO head to rf_*, we=1.
  - Next: stall_o <= 0, age <= 0, state <= NORMAL.
- Simultaneous push and pop in one cycle: count unchanged.
- When full, lu_ready_o=0 and LU must hold lu_valid_i/data.
- Write latency: rf_* reflects the winning request one posedge after it is presented. The register file samples on the following negedge.
- FIFO pops in push order. Ordering between WB and LU writes to the same register is the scoreboard's responsibility (see optional feature).
- Pointers wrap modulo DEPTH. count is exact, from 0 to DEPTH.

Optional Feature:
- Macro RF_ARB_PENDCHK_EN.
- Defined: adds ports chk_addr_i (in, 5) and chk_hit_o (out, 1). chk_hit_o is combinational and is 1 iff any valid FIFO entry has addr==chk_addr_i, or the in-flight rf_we_o/rf_addr_o matches. Used by hazard detection to stall readers of pending registers. chk_addr_i==0 → chk_hit_o=0.
- Undefined: ports absent, no comparators.

Test Plan:
- Reset: drive rst_n=0 for 2 cycles with traffic active → all outputs 0, pend_cnt_o=0, lu_ready_o=1.
- WB only: wb_we_i=1, addr=5, data=0xDEADBEEF → next posedge rf_we_o=1, rf_addr_o=5, rf_data_o=0xDEADBEEF. Same with addr=0 → rf_we_o=0.
- LU idle pipeline: push addr=7, data=0x12345678 with wb_we_i=0 → pop on the following posedge, so rf_we_o=1 with addr=7 two posedges after push; pend_cnt_o returns to 0.
- Starvation: push one LU entry, then hold wb_we_i=1 (addr=3) continuously → stall_o=1 for one cycle after 8 waiting cycles, that cycle writes the LU entry, then WB resumes with addr=3.
- Full: push 4 entries with WB busy → lu_ready_o=0 and a 5th lu_valid_i is not accepted. After one pop, lu_ready_o=1 and entries pop in push order.
- RF_ARB_PENDCHK_EN: with addr=9 pending, chk_addr_i=9 → chk_hit_o=1, and stays 1 through the write cycle. After rf_we_o drops, chk_hit_o=0. chk_addr_i=0 → chk_hit_o=0.
